// File: rtl/mult_job_dispatcher.sv
// Initiator for the multiplier start/done handshake: accepts one operand pair, pulses start,
// tracks the engine through done, and returns the result. Optional abort timer: MULT_DISPATCH_TIMEOUT_EN.
module mult_job_dispatcher #(
   parameter int DATA_W      = 16,
   parameter int RES_W       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              start,
   input  logic              done,
   input  logic [RES_W-1:0]  result_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  out_result,
   output logic              out_err,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_OUT
   } state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   capture;
   logic   timeout_hit;

   if (TIMEOUT_CYC < 1) begin : g_timeout_range
      $error("TIMEOUT_CYC must be at least 1");
   end

   // The engine only idles with done=1, so an accept is only offered then.
   assign in_ready  = (state == S_IDLE) && done;
   assign accept    = in_valid && in_ready;
   assign start     = (state == S_ISSUE);
   assign out_valid = (state == S_OUT);
   assign busy      = (state != S_IDLE);
   assign capture   = (state == S_WAIT_DONE) && done;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (accept) state_nxt = S_ISSUE;
         S_ISSUE:     state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (timeout_hit)  state_nxt = S_OUT;
            else if (!done)   state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (done || timeout_hit) state_nxt = S_OUT;
         end
         S_OUT:       if (out_ready) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operands are held for the whole job; the engine samples them after start.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
      end else if (accept) begin
         op_a <= in_a;
         op_b <= in_b;
      end
   end

   // A normal completion wins over a timeout landing on the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_result <= '0;
         out_err    <= 1'b0;
      end else if (capture) begin
         out_result <= result_in;
         out_err    <= 1'b0;
      end else if (timeout_hit) begin
         out_result <= {RES_W{1'b1}};
         out_err    <= 1'b1;
      end
   end

`ifdef MULT_DISPATCH_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] to_cnt;
   logic             waiting;
   logic             waiting_nxt;

   assign waiting     = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
   assign waiting_nxt = (state_nxt == S_WAIT_BUSY) || (state_nxt == S_WAIT_DONE);

   // to_cnt counts wait cycles already spent, so this fires on the TIMEOUT_CYC-th wait cycle.
   assign timeout_hit = waiting && !capture && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (waiting && waiting_nxt) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mult_job_dispatcher.sv
// Scoreboard bench for mult_job_dispatcher with a behavioural start/done engine model.
module tb_mult_job_dispatcher;

   localparam int DW = 16;
   localparam int RW = 32;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_a, in_b, op_a, op_b;
   logic          start, done;
   logic [RW-1:0] result_in;
   logic          out_valid, out_ready;
   logic [RW-1:0] out_result;
   logic          out_err, busy;

   logic          eng_done   = 1'b1;
   logic          force_busy = 1'b0;
   logic          eng_never  = 1'b0;
   logic [RW-1:0] eng_result = '0;
   int            eng_lat    = 12;
   int            rise_cyc   = 0;
   int            cyc        = 0;
   int            start_cnt  = 0;

   typedef struct {
      logic [RW-1:0] res;
      logic          err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;

   assign done      = eng_done & ~force_busy;
   assign result_in = eng_result;

   mult_job_dispatcher #(
      .DATA_W     (DW),
      .RES_W      (RW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .op_a      (op_a),
      .op_b      (op_b),
      .start     (start),
      .done      (done),
      .result_in (result_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (start) start_cnt <= start_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Engine model: drops done one cycle after start, raises it eng_lat cycles later with the product.
   initial begin : engine
      logic [DW-1:0] ea, eb;
      forever begin
         @(negedge clk);
         if (start) begin
            ea = op_a;
            eb = op_b;
            step();
            eng_done = 1'b0;
            repeat (eng_lat) @(posedge clk);
            while (eng_never) @(posedge clk);
            #1;
            eng_result = RW'(ea) * RW'(eb);
            eng_done   = 1'b1;
            rise_cyc   = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("out_result", out_result, mon_e.res);
            check("out_err", out_err, mon_e.err);
         end
      end
   end

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] res, input logic err, input bit track);
      bit ok = 0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      if (track) sb.push_back('{res: res, err: err});
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_bound", 0, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int waits);
      bit ok = 0;
      waits = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            break;
         end
         if (busy && !start) waits++;
      end
      if (!ok) check("out_valid_bound", 0, 1);
   endtask

   task automatic wait_engine_idle();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("engine_idle_bound", 0, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int w, sc;
      bit ok;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;

      repeat (2) step();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_start", start, 0);
      check("rst_op_a", op_a, 0);
      check("rst_op_b", op_b, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_err", out_err, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);

      // Basic job with latency checks
      step();
      out_ready = 1'b1;
      send(16'd7, 16'd9, 32'd63, 1'b0, 1);
      @(negedge clk);
      check("basic_start", start, 1);
      check("basic_op_a", op_a, 7);
      check("basic_op_b", op_b, 9);
      check("basic_in_ready", in_ready, 0);
      check("basic_busy", busy, 1);
      step();
      @(negedge clk);
      check("basic_start_pulse", start, 0);
      wait_out(w);
      check("done_to_valid", cyc - rise_cyc, 1);

      // Backpressure, with the next pair waiting upstream
      step();
      out_ready = 1'b0;
      send(16'd11, 16'd13, 32'd143, 1'b0, 1);
      wait_out(w);
      step();
      in_a     = 16'd2;
      in_b     = 16'd4;
      in_valid = 1'b1;
      sb.push_back('{res: 32'd8, err: 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result", out_result, 143);
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_hs_in_ready", in_ready, 0);
      step();
      @(negedge clk);
      check("bp_accept_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_next_start", start, 1);
      check("bp_next_op_a", op_a, 2);
      wait_out(w);

      // Engine not ready: done low blocks the accept
      step();
      force_busy = 1'b1;
      in_a       = 16'd6;
      in_b       = 16'd7;
      in_valid   = 1'b1;
      sb.push_back('{res: 32'd42, err: 1'b0});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("nr_in_ready", in_ready, 0);
         check("nr_start", start, 0);
         check("nr_busy", busy, 0);
         step();
      end
      force_busy = 1'b0;
      @(negedge clk);
      check("nr_ready_on_done", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("nr_start_after", start, 1);
      wait_out(w);

      // Reset in WAIT_DONE
      step();
      send(16'd5, 16'd5, '0, 1'b0, 0);
      repeat (4) step();
      @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_out_valid", out_valid, 0);
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_op_a", op_a, 0);
      check("mid_rst_start", start, 0);
      step();
      rst = 1'b0;
      wait_engine_idle();

      // Back-to-back jobs, one start each
      step();
      sc = start_cnt;
      send(16'd3, 16'd5, 32'd15, 1'b0, 1);
      send(16'd0, 16'd9, 32'd0, 1'b0, 1);
      send(16'd65535, 16'd65535, 32'hFFFE0001, 1'b0, 1);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check("b2b_drain", ok, 1);
      step();
      check("b2b_starts", start_cnt - sc, 3);

`ifdef MULT_DISPATCH_TIMEOUT_EN
      // Engine never finishes: abort after TO wait cycles
      eng_never = 1'b1;
      send(16'd1, 16'd1, {RW{1'b1}}, 1'b1, 1);
      wait_out(w);
      check("to_wait_cycles", w, TO);
      check("to_err", out_err, 1);
      step();
      eng_never = 1'b0;
      wait_engine_idle();
`endif

      repeat (3) step();
      check("sb_empty_end", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
